// File: rtl/conv_pkg.sv
// conv_pkg - shared defaults, FSM state type and tap indices for the 3x3 window generator (rev 1.0).
`default_nettype none

package conv_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_HEIGHT = 8;
  localparam int DEF_BITW   = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Row-major tap indices; W00 is the top-left (oldest row, oldest column).
  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W02 = 2;
  localparam int W10 = 3;
  localparam int W11 = 4;
  localparam int W12 = 5;
  localparam int W20 = 6;
  localparam int W21 = 7;
  localparam int W22 = 8;

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// conv_line_buffer - one image row of pixels, single address, read-before-write (rev 1.0).
`default_nettype none

module conv_line_buffer #(
  parameter int WIDTH = 8,
  parameter int BITW  = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(WIDTH)-1:0] addr_i,
  input  logic [BITW-1:0]          wdata_i,
  output logic [BITW-1:0]          rdata_o
);

  logic [BITW-1:0] mem_q [WIDTH];

  // Asynchronous read returns the old entry while the same entry is overwritten at the edge.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen - streaming 3x3 window generator with two line buffers, rev 1.0.
// Optional macro CONV_WIN_COORD_EN adds out_x/out_y centre-coordinate ports.
`default_nettype none

module conv3x3_window_gen
  import conv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int BITW   = DEF_BITW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITW-1:0]           in_pix,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [9*BITW-1:0]         out_win,
  output logic                      out_border,
`ifdef CONV_WIN_COORD_EN
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
`endif
  output logic                      out_last
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  state_e          state_q;
  logic [XW-1:0]   in_x_q, ox_q;
  logic [YW-1:0]   in_y_q, oy_q;
  logic [BITW-1:0] win_q [9];
  logic [BITW-1:0] win_d [9];
  logic [9*BITW-1:0] win_flat;
  logic [BITW-1:0] lb0_rd, lb1_rd;

  logic              out_valid_q, out_border_q, out_last_q;
  logic [9*BITW-1:0] out_win_q;

  logic slot_free, acc, load, done, ld_border, ld_last, in_last, fill_done;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !rst && (state_q != FLUSH) && slot_free;
  assign acc       = in_valid && in_ready;

  // ox_q/oy_q hold the centre of the next window to be loaded into the output register.
  assign ld_border = (ox_q == '0) || (ox_q == XMAX) || (oy_q == '0) || (oy_q == YMAX);
  assign ld_last   = (ox_q == XMAX) && (oy_q == YMAX);
  assign in_last   = (in_x_q == XMAX) && (in_y_q == YMAX);
  assign fill_done = (in_x_q == '0) && (in_y_q == YW'(1));

  assign done = (state_q == FLUSH) && out_valid_q && out_ready && out_last_q;
  assign load = ((state_q == RUN) && acc) ||
                ((state_q == FLUSH) && slot_free && !(out_valid_q && out_last_q));

  conv_line_buffer #(.WIDTH(WIDTH), .BITW(BITW)) u_lb0 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (in_x_q),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  conv_line_buffer #(.WIDTH(WIDTH), .BITW(BITW)) u_lb1 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (in_x_q),
    .wdata_i (in_pix),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    win_d[W00] = win_q[W01];
    win_d[W01] = win_q[W02];
    win_d[W02] = lb0_rd;
    win_d[W10] = win_q[W11];
    win_d[W11] = win_q[W12];
    win_d[W12] = lb1_rd;
    win_d[W20] = win_q[W21];
    win_d[W21] = win_q[W22];
    win_d[W22] = in_pix;
    win_flat   = '0;
    for (int t = 0; t < 9; t++) begin
      win_flat[t*BITW +: BITW] = win_d[t];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int t = 0; t < 9; t++) begin
        win_q[t] <= win_d[t];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      in_x_q       <= '0;
      in_y_q       <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      out_valid_q  <= 1'b0;
      out_win_q    <= '0;
      out_border_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      if (acc) begin
        in_x_q <= (in_x_q == XMAX) ? '0 : in_x_q + 1'b1;
        if (in_x_q == XMAX) begin
          in_y_q <= (in_y_q == YMAX) ? '0 : in_y_q + 1'b1;
        end
      end

      case (state_q)
        FILL:    if (acc && fill_done) state_q <= RUN;
        RUN:     if (acc && in_last)   state_q <= FLUSH;
        FLUSH:   if (done)             state_q <= FILL;
        default: state_q <= FILL;
      endcase

      if (load) begin
        out_valid_q  <= 1'b1;
        out_win_q    <= ld_border ? '0 : win_flat;
        out_border_q <= ld_border;
        out_last_q   <= ld_last;
        ox_q         <= (ox_q == XMAX) ? '0 : ox_q + 1'b1;
        if (ox_q == XMAX) begin
          oy_q <= (oy_q == YMAX) ? '0 : oy_q + 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (done) begin
        in_x_q <= '0;
        in_y_q <= '0;
        ox_q   <= '0;
        oy_q   <= '0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_win    = out_win_q;
  assign out_border = out_border_q;
  assign out_last   = out_last_q;

`ifdef CONV_WIN_COORD_EN
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_x_q <= '0;
      out_y_q <= '0;
    end else if (load) begin
      out_x_q <= ox_q;
      out_y_q <= oy_q;
    end
  end

  assign out_x = out_x_q;
  assign out_y = out_y_q;
`endif

endmodule

`default_nettype wire
